// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Resolves branches in EX and predicts them in IF. Prediction uses a
// direct-mapped branch target buffer (BTB). Each entry holds a full tag and
// an N-bit saturating counter. The IF lookup is purely combinational and
// reads the registered tables. EX resolution is also combinational. It
// flags mispredicts and supplies the redirect PC. The tables and the
// performance counters are trained on the following rising clock edge.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush_bt          synchronous invalidate of every BTB entry
//   pc_if             fetch PC
//   pred_taken        IF prediction
//   pred_target       next fetch PC (predicted target or pc_if+4)
//   ex_valid          EX holds a real instruction
//   ex_pc             PC of the EX instruction
//   br_type           branch type (see BR_* encodings below)
//   reg1, reg2        branch operands
//   ex_target         computed branch target
//   ex_pred_taken     prediction carried down with the instruction
//   ex_pred_target    predicted target carried down with the instruction
//   br_taken          resolved outcome
//   mispredict        redirect required
//   redirect_pc       correct next PC; meaningful only while mispredict=1
//   stat_branches     resolved branch count (saturating)
//   stat_mispredicts  mispredicted branch count (saturating)
// ---------------------------------------------------------------------------
module branch_predict_unit #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int CNT_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_bt,
  input  logic [XLEN-1:0]   pc_if,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [2:0]        br_type,
  input  logic [XLEN-1:0]   reg1,
  input  logic [XLEN-1:0]   reg2,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  output logic              br_taken,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  localparam logic [2:0] BR_NOBRANCH = 3'd0;
  localparam logic [2:0] BR_BEQ      = 3'd1;
  localparam logic [2:0] BR_BNE      = 3'd2;
  localparam logic [2:0] BR_BLT      = 3'd3;
  localparam logic [2:0] BR_BLTU     = 3'd4;
  localparam logic [2:0] BR_BGE      = 3'd5;
  localparam logic [2:0] BR_BGEU     = 3'd6;

  // Counter landmarks: MSB set means "predict taken".
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS - 1));

  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // BTB storage (flop arrays)
  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

  // -------------------------------------------------------------------------
  // IF lookup. It reads only registered state, so an EX update to the same
  // index is not visible until after the edge.
  // -------------------------------------------------------------------------
  logic [IDX-1:0]   if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx      = pc_if[IDX+1:2];
  assign if_tag      = pc_if[XLEN-1:IDX+2];
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && cnt_q[if_idx][CNT_BITS-1];
  assign pred_target = pred_taken ? target_q[if_idx] : pc_if + XLEN'(4);

  // -------------------------------------------------------------------------
  // EX resolution
  // -------------------------------------------------------------------------
  logic is_branch;
  logic cond;

  always_comb begin
    is_branch = 1'b0;
    cond      = 1'b0;
    case (br_type)
      BR_BEQ:  begin is_branch = 1'b1; cond = (reg1 == reg2); end
      BR_BNE:  begin is_branch = 1'b1; cond = (reg1 != reg2); end
      BR_BLT:  begin is_branch = 1'b1; cond = ($signed(reg1) <  $signed(reg2)); end
      BR_BGE:  begin is_branch = 1'b1; cond = ($signed(reg1) >= $signed(reg2)); end
      BR_BLTU: begin is_branch = 1'b1; cond = (reg1 <  reg2); end
      BR_BGEU: begin is_branch = 1'b1; cond = (reg1 >= reg2); end
      default: begin is_branch = 1'b0; cond = 1'b0; end
    endcase
  end

  assign br_taken    = ex_valid && cond;
  // A taken prediction on a non-branch is also a mispredict, because
  // br_taken is 0 for those codes.
  assign mispredict  = ex_valid &&
                       ((br_taken != ex_pred_taken) ||
                        (br_taken && (ex_pred_target != ex_target)));
  assign redirect_pc = br_taken ? ex_target : ex_pc + XLEN'(4);

  // -------------------------------------------------------------------------
  // Training
  // -------------------------------------------------------------------------
  logic [IDX-1:0]   ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;

  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (flush_bt) begin
      // A flush overrides any training or allocation in the same cycle.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (ex_valid) begin
      if (is_branch) begin
        if (ex_hit) begin
          if (br_taken) begin
            target_q[ex_idx] <= ex_target;
            if (cnt_q[ex_idx] != CNT_MAX) begin
              cnt_q[ex_idx] <= cnt_q[ex_idx] + CNT_BITS'(1);
            end
          end else if (cnt_q[ex_idx] != '0) begin
            cnt_q[ex_idx] <= cnt_q[ex_idx] - CNT_BITS'(1);
          end
        end else if (br_taken) begin
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= ex_target;
          cnt_q[ex_idx]    <= CNT_WT;
        end
      end else if ((br_type == BR_NOBRANCH) && ex_hit) begin
        // A non-branch that hits means a stale entry. Drop that entry.
        valid_q[ex_idx] <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Performance counters. They saturate at all-ones and do not wrap.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (ex_valid && is_branch) begin
      if (stat_branches != STAT_MAX) begin
        stat_branches <= stat_branches + STAT_W'(1);
      end
      if (mispredict && (stat_mispredicts != STAT_MAX)) begin
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  localparam int NE = 64;

  logic        clk;
  logic        rst_n;
  logic        flush_bt;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  br_type;
  logic [31:0] reg1, reg2;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        br_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_predict_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_bt         (flush_bt),
    .pc_if            (pc_if),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .br_type          (br_type),
    .reg1             (reg1),
    .reg2             (reg2),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .br_taken         (br_taken),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int n_br  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model. It works from PC arithmetic and integer counters.
  // ------------------------------------------------------------------
  bit          m_valid [NE];
  int unsigned m_tag   [NE];
  logic [31:0] m_tgt   [NE];
  int          m_cnt   [NE];
  int unsigned m_br, m_mis;

  function automatic int ix(input logic [31:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[ix(pc)] && (m_tag[ix(pc)] == (pc >> 8));
  endfunction

  function automatic bit is_br(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd6);
  endfunction

  function automatic bit outcome(input bit v, input logic [2:0] t,
                                 input logic [31:0] a, input logic [31:0] b);
    if (!v) return 1'b0;
    case (t)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return int'(a) < int'(b);
      3'd4: return a < b;
      3'd5: return int'(a) >= int'(b);
      3'd6: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_mispred();
    bit tk;
    tk = outcome(ex_valid, br_type, reg1, reg2);
    return ex_valid && ((tk != ex_pred_taken) || (tk && ex_pred_target != ex_target));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 1;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic m_train();
    bit tk, mp, h;
    int i;
    tk = outcome(ex_valid, br_type, reg1, reg2);
    mp = m_mispred();
    h  = m_hit(ex_pc);
    i  = ix(ex_pc);
    if (ex_valid && is_br(br_type)) begin
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (mp && m_mis != 32'hFFFF_FFFF) m_mis++;
    end
    if (flush_bt) begin
      for (int k = 0; k < NE; k++) m_valid[k] = 0;
    end else if (ex_valid && is_br(br_type)) begin
      if (h) begin
        if (tk) begin
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_tgt[i] = ex_target;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (tk) begin
        m_valid[i] = 1;
        m_tag[i]   = ex_pc >> 8;
        m_tgt[i]   = ex_target;
        m_cnt[i]   = 2;
      end
    end else if (ex_valid && br_type == 3'd0 && h) begin
      m_valid[i] = 0;
    end
  endtask

  initial m_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_train();
  end

  // Per-cycle compare, on the falling edge
  always @(negedge clk) begin
    bit          ep, tk, mp;
    logic [31:0] et;
    ep = m_hit(pc_if) && (m_cnt[ix(pc_if)] >= 2);
    et = ep ? m_tgt[ix(pc_if)] : pc_if + 32'd4;
    tk = outcome(ex_valid, br_type, reg1, reg2);
    mp = m_mispred();
    chk("m_pred_taken",  pred_taken,  ep);
    chk("m_pred_target", pred_target, et);
    chk("m_br_taken",    br_taken,    tk);
    chk("m_mispredict",  mispredict,  mp);
    if (mp) chk("m_redirect", redirect_pc, tk ? ex_target : ex_pc + 32'd4);
    chk("m_stat_br",  stat_branches,    m_br);
    chk("m_stat_mis", stat_mispredicts, m_mis);
  end

  // ------------------------------------------------------------------
  // Directed stimulus
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] pc);
    ex_valid = 1'b0;
    br_type  = 3'd0;
    pc_if    = pc;
  endtask

  task automatic ex(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] tg, input bit pt,
                    input logic [31:0] ptg);
    ex_valid       = 1'b1;
    br_type        = t;
    ex_pc          = pc;
    reg1           = a;
    reg2           = b;
    ex_target      = tg;
    ex_pred_taken  = pt;
    ex_pred_target = ptg;
    if (is_br(t)) n_br++;
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    bit          exp;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{3'd1, 32'd3,          32'd4,          1'b0};
    vt[1] = '{3'd2, 32'd3,          32'd4,          1'b1};
    vt[2] = '{3'd3, 32'd1,          32'hFFFF_FFFF,  1'b0};
    vt[3] = '{3'd5, 32'd1,          32'hFFFF_FFFF,  1'b1};
    vt[4] = '{3'd6, 32'd1,          32'hFFFF_FFFF,  1'b0};
    vt[5] = '{3'd4, 32'd1,          32'hFFFF_FFFF,  1'b1};
    vt[6] = '{3'd5, 32'd5,          32'd5,          1'b1};
    vt[7] = '{3'd6, 32'd5,          32'd5,          1'b1};
    vt[8] = '{3'd3, 32'h8000_0000,  32'h7FFF_FFFF,  1'b1};
    vt[9] = '{3'd7, 32'd5,          32'd5,          1'b0};

    rst_n = 1'b1; flush_bt = 1'b0; pc_if = 32'h100;
    ex_valid = 1'b0; br_type = 3'd0; ex_pc = '0; reg1 = '0; reg2 = '0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;

    tick();
    idle(32'h100); #1;
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_pred_target", pred_target, 32'h104);
    chk("rst_stat_br", stat_branches, 0);
    chk("rst_stat_mis", stat_mispredicts, 0);

    // Signed less-than, taken, allocates the entry
    ex(3'd3, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h80, 1'b0, 32'h0); #1;
    chk("blt_taken", br_taken, 1);
    chk("blt_mispredict", mispredict, 1);
    chk("blt_redirect", redirect_pc, 32'h80);
    tick();
    idle(32'h100); #1;
    chk("alloc_pred_taken", pred_taken, 1);
    chk("alloc_pred_target", pred_target, 32'h80);
    chk("alloc_stat_mis", stat_mispredicts, 1);

    // Unsigned version, not taken; then decrement to the floor
    ex(3'd4, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h80, 1'b1, 32'h80); #1;
    chk("bltu_taken", br_taken, 0);
    chk("bltu_redirect", redirect_pc, 32'h104);
    tick();
    for (int k = 0; k < 4; k++) begin
      ex(3'd4, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h80, 1'b0, 32'h0);
      tick();
    end
    idle(32'h100); #1;
    chk("floor_pred", pred_taken, 0);
    // One taken step from the floor must still predict not-taken
    ex(3'd3, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h80, 1'b0, 32'h0);
    tick();
    idle(32'h100); #1;
    chk("nowrap_pred", pred_taken, 0);

    // Saturate upward at 0x200, then one not-taken step keeps the prediction
    for (int k = 0; k < 6; k++) begin
      ex(3'd1, 32'h200, 32'd5, 32'd5, 32'h300, k != 0, 32'h300);
      tick();
    end
    ex(3'd2, 32'h200, 32'd5, 32'd5, 32'h300, 1'b1, 32'h300);
    tick();
    idle(32'h200); #1;
    chk("sat_pred", pred_taken, 1);
    chk("sat_target", pred_target, 32'h300);

    // Right direction, wrong target
    ex(3'd1, 32'h200, 32'd5, 32'd5, 32'h300, 1'b1, 32'h400); #1;
    chk("tgt_mispredict", mispredict, 1);
    chk("tgt_redirect", redirect_pc, 32'h300);
    tick();
    ex(3'd1, 32'h200, 32'd5, 32'd5, 32'h344, 1'b1, 32'h300);
    tick();
    idle(32'h200); #1;
    chk("tgt_update", pred_target, 32'h344);

    // Resolution table
    for (int k = 0; k < 10; k++) begin
      ex(vt[k].t, 32'h600 + 32'(k * 4), vt[k].a, vt[k].b, 32'h900, 1'b0, 32'h0); #1;
      chk($sformatf("vec%0d_taken", k), br_taken, vt[k].exp);
      tick();
    end

    // Non-branch predicted taken: mispredict, and the entry is dropped
    ex(3'd0, 32'h200, 32'd0, 32'd0, 32'h0, 1'b1, 32'h344); #1;
    chk("nob_mispredict", mispredict, 1);
    chk("nob_redirect", redirect_pc, 32'h204);
    tick();
    idle(32'h200); #1;
    chk("nob_inval", pred_taken, 0);

    // Bubble resolves nothing
    ex(3'd1, 32'h200, 32'd5, 32'd5, 32'h300, 1'b0, 32'h0);
    n_br--;
    ex_valid = 1'b0; #1;
    chk("bubble_taken", br_taken, 0);
    chk("bubble_mispredict", mispredict, 0);
    tick();

    // Flush together with an allocating branch
    ex(3'd1, 32'h240, 32'd1, 32'd1, 32'h500, 1'b0, 32'h0);
    tick();
    idle(32'h240); #1;
    chk("pre_flush_pred", pred_taken, 1);
    ex(3'd1, 32'h500, 32'd1, 32'd1, 32'h700, 1'b0, 32'h0);
    flush_bt = 1'b1;
    tick();
    flush_bt = 1'b0;
    idle(32'h240); #1;
    chk("flush_old", pred_taken, 0);
    pc_if = 32'h500; #1;
    chk("flush_new", pred_taken, 0);
    chk("flush_stat_br", stat_branches, n_br);

    // Asynchronous reset in mid-run
    ex(3'd1, 32'h240, 32'd1, 32'd1, 32'h500, 1'b0, 32'h0);
    tick();
    idle(32'h240); #1;
    chk("pre_rst_pred", pred_taken, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pred", pred_taken, 0);
    chk("arst_stat_br", stat_branches, 0);
    chk("arst_stat_mis", stat_mispredicts, 0);
    n_br = 0;
    #10 rst_n = 1'b1;
    ex(3'd1, 32'h240, 32'd1, 32'd1, 32'h500, 1'b0, 32'h0);
    tick();
    idle(32'h240); #1;
    chk("post_rst_stat_br", stat_branches, n_br);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the EX-stage branch decision logic. It resolves branches at any data width and adds prediction: a direct-mapped branch target buffer (BTB) with per-entry N-bit saturating counters.
- IF side: combinational lookup against registered tables.
- EX side: resolves the branch, flags mispredicts, supplies the redirect PC, trains the tables on the next clock edge, and keeps performance counters.

Parameters:
- XLEN, 32, datapath/PC width.
- ENTRIES, 64, BTB entries; power of 2, ≥2; IDX = log2(ENTRIES).
- CNT_BITS, 2, saturating counter width (≥1).
- STAT_W, 32, width of performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_bt  in  1  synchronous invalidate of all BTB entries.
- pc_if  in  XLEN  fetch PC.
- pred_taken  out  1  IF prediction.
- pred_target  out  XLEN  next fetch PC.
- ex_valid  in  1  EX holds a real instruction (not bubble/stalled).
- ex_pc  in  XLEN  PC of EX instruction.
- br_type  in  3  branch type; encodings from project Parameters header (NOBRANCH, BEQ, BNE, BLT, BLTU, BGE, BGEU).
- reg1, reg2  in  XLEN  operands.
- ex_target  in  XLEN  computed branch target.
- ex_pred_taken  in  1  prediction carried down with the instruction.
- ex_pred_target  in  XLEN  predicted target carried down.
- br_taken  out  1  actual outcome.
- mispredict  out  1  redirect required.
- redirect_pc  out  XLEN  correct next PC.
- stat_branches  out  STAT_W  resolved branches.
- stat_mispredicts  out  STAT_W  mispredicts.

Behaviour:
- Addressing:
  - idx = pc[IDX+1:2].
  - tag = pc[XLEN-1:IDX+2] (full tag, so no aliasing).
  - Per entry: valid, tag, target, cnt.
- Reset (async, rst_n=0):
  - All valid=0.
  - All cnt = 2^(CNT_BITS-1)-1 (weakly not-taken).
  - Stats=0.
  - Outputs follow their combinational definitions: with no valid entries, pred_taken=0 and pred_target=pc_if+4.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && cnt[idx] MSB.
  - pred_target = pred_taken ? target[idx] : pc_if+4 (mod 2^XLEN).
- Resolution (combinational):
  - br_taken = 0 when ex_valid=0, NOBRANCH, or unknown code.
  - BEQ/BNE: equality.
  - BLT/BGE: signed XLEN compare.
  - BLTU/BGEU: unsigned compare.
- Mispredict:
  - mispredict = ex_valid && (br_taken != ex_pred_taken || (br_taken && ex_pred_target != ex_target)).
  - A NOBRANCH instruction with ex_pred_taken=1 is a mispredict.
  - redirect_pc = br_taken ? ex_target : ex_pc+4. Valid only while mispredict=1.
- Training (posedge, when ex_valid and br_type is a branch):
  - Hit on ex_pc: cnt += 1 if taken, else cnt -= 1, saturating at 2^CNT_BITS-1 and 0. On taken, target := ex_target.
  - Miss and taken: allocate/replace: valid=1, tag, target=ex_target, cnt=2^(CNT_BITS-1) (weakly taken).
  - Miss and not taken: no change.
  - NOBRANCH with hit on ex_pc: entry invalidated.
- Stats (posedge, when ex_valid and br_type is a branch):
  - stat_branches += 1.
  - stat_mispredicts += mispredict.
  - Both saturate at all-ones; no wrap.
- Simultaneous events:
  - IF lookup and EX update on the same idx: lookup sees the pre-edge entry (no bypass).
  - flush_bt with a training update: flush wins; all valid=0 and no allocation. Stats still count.
  - Reset mid-operation: immediate clear of tables and stats regardless of clock.
- Tables are flop arrays; no RAM inference required.

Test Plan:
- Reset, pc_if=0x100 → pred_taken=0, pred_target=0x104; stats=0.
- Resolve BLT at 0x100, reg1=0xFFFFFFFF, reg2=1, ex_target=0x80, ex_pred_taken=0 → br_taken=1, mispredict=1, redirect_pc=0x80. Next cycle pc_if=0x100 → pred_taken=1, pred_target=0x80. stat_mispredicts=1.
- Same operands as BLTU → br_taken=0, redirect_pc=0x104. Four not-taken updates → cnt saturates at 0 and the fifth does not wrap; prediction stays not-taken.
- Four taken BEQ updates at 0x200 (reg1=reg2=5, ex_target=0x300) → cnt saturates at 3; the fifth taken update holds 3.
- Taken branch with ex_pred_taken=1 but ex_pred_target=0x400, ex_target=0x300 → mispredict=1, redirect_pc=0x300, BTB target updated to 0x300.
- Flush_bt on the same edge as an allocating taken branch → no entry valid afterwards, stat_branches still increments. Pulse rst_n low mid-run → tables and stats clear asynchronously.
